// File: rtl/vram_arbiter.sv
// vram_arbiter: video-priority arbiter sharing one synchronous VRAM port with the CPU.
// Optional contention statistics counter: define VRAM_ARB_STATS_EN.
`default_nettype none

module vram_arbiter #(
  parameter int AW         = 14,
  parameter int STARVE_MAX = 6
) (
  input  logic          clk,
  input  logic          rst,
`ifdef VRAM_ARB_STATS_EN
  input  logic          stat_clr,
  output logic [15:0]   stat_cont,
`endif
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic [7:0]    vid_data,
  output logic          vid_valid,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic [7:0]    cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_wait,
  output logic          cpu_starved,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  output logic          mem_we,
  input  logic [7:0]    mem_rdata
);

  localparam logic [2:0] C_IDLE   = 3'd0;
  localparam logic [2:0] C_PEND   = 3'd1;
  localparam logic [2:0] C_FLIGHT = 3'd2;
  localparam logic [2:0] C_ACK    = 3'd3;
  localparam logic [2:0] C_HOLD   = 3'd4;

  localparam logic [4:0] STARVE_TH = 5'(STARVE_MAX);

  logic [2:0]    state_q, state_d;
  logic [3:0]    cont_q;
  logic          vid_p1_q, cpu_rd_p1_q, vid_valid_q;
  logic [7:0]    vid_data_q, cpu_rdata_q;
  logic [AW-1:0] mem_addr_q;
  logic [7:0]    mem_wdata_q;
  logic          vid_issue, cpu_issue, wait_w;
  logic [4:0]    cont_now;

  always_comb begin
    vid_issue = vid_req && !rst;
    cpu_issue = !vid_req && (state_q == C_PEND) && !rst;
    // A request rising this cycle already counts as waiting if video holds the port.
    wait_w    = !rst && vid_req &&
                ((state_q == C_PEND) || ((state_q == C_IDLE) && cpu_req));
    cont_now  = {1'b0, cont_q} + {4'b0, wait_w};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      C_IDLE:   if (cpu_req)   state_d = C_PEND;
      C_PEND:   if (cpu_issue) state_d = C_FLIGHT;
      C_FLIGHT:                state_d = C_ACK;
      C_ACK:                   state_d = C_HOLD;
      C_HOLD:   if (!cpu_req)  state_d = C_IDLE;
      default:                 state_d = C_IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    mem_we    = 1'b0;
    if (rst) begin
      mem_addr  = '0;
      mem_wdata = '0;
    end else if (vid_issue) begin
      mem_addr  = vid_addr;
    end else if (cpu_issue) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= C_IDLE;
      cont_q      <= '0;
      vid_p1_q    <= 1'b0;
      cpu_rd_p1_q <= 1'b0;
      vid_valid_q <= 1'b0;
      vid_data_q  <= '0;
      cpu_rdata_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      vid_p1_q    <= vid_issue;
      cpu_rd_p1_q <= cpu_issue && !cpu_we;
      vid_valid_q <= vid_p1_q;
      mem_addr_q  <= mem_addr;
      mem_wdata_q <= mem_wdata;
      if (vid_p1_q)    vid_data_q  <= mem_rdata;
      if (cpu_rd_p1_q) cpu_rdata_q <= mem_rdata;
      if (cpu_issue)
        cont_q <= '0;
      else if (wait_w && (cont_q != 4'hF))
        cont_q <= cont_q + 4'd1;
    end
  end

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] stat_q;

  always_ff @(posedge clk) begin
    if (rst || stat_clr)
      stat_q <= '0;
    else if (wait_w && (stat_q != 16'hFFFF))
      stat_q <= stat_q + 16'd1;
  end

  assign stat_cont = stat_q;
`endif

  // The starvation flag includes the current contended cycle so it rises on the Nth one.
  assign cpu_starved = !rst && (cont_now >= STARVE_TH);
  assign cpu_wait    = wait_w;
  assign cpu_ack     = !rst && (state_q == C_ACK);
  assign vid_valid   = !rst && vid_valid_q;
  assign vid_data    = vid_data_q;
  assign cpu_rdata   = cpu_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed self-checking bench with a RAM model and result scoreboards.
`default_nettype none

module tb_vram_arbiter;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic [7:0]    vid_data;
  logic          vid_valid;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata, cpu_rdata;
  logic          cpu_ack, cpu_wait, cpu_starved;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_we;
  logic [7:0]    mem_rdata;
`ifdef VRAM_ARB_STATS_EN
  logic          stat_clr;
  logic [15:0]   stat_cont;
`endif

  logic [7:0] ram   [0:(1<<AW)-1];
  logic [7:0] model [0:(1<<AW)-1];
  logic [7:0] vid_exp[$];
  logic [7:0] cpu_exp[$];
  logic [7:0] last_rd;
  int total = 0;
  int bad   = 0;

  vram_arbiter #(.AW(AW), .STARVE_MAX(6)) dut (
    .clk(clk), .rst(rst),
`ifdef VRAM_ARB_STATS_EN
    .stat_clr(stat_clr), .stat_cont(stat_cont),
`endif
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_wait(cpu_wait), .cpu_starved(cpu_starved),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: read-before-write, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every completion pops the value queued when its request was driven.
  always @(negedge clk) begin
    if (vid_valid) begin
      chk("vid_expected", (vid_exp.size() > 0), 1);
      if (vid_exp.size() > 0) chk("vid_data_sb", vid_data, vid_exp.pop_front());
    end
    if (cpu_ack) begin
      chk("cpu_expected", (cpu_exp.size() > 0), 1);
      if (cpu_exp.size() > 0) chk("cpu_rdata_sb", cpu_rdata, cpu_exp.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]   = 8'(i) ^ 8'h3C;
      model[i] = 8'(i) ^ 8'h3C;
    end
    ram[14'h1800] = 8'h47; model[14'h1800] = 8'h47;
    rst = 1'b1; vid_req = 0; vid_addr = '0; cpu_req = 0; cpu_we = 0;
    cpu_addr = '0; cpu_wdata = '0; last_rd = 8'h00;
`ifdef VRAM_ARB_STATS_EN
    stat_clr = 0;
`endif
    cyc(); cyc();
    @(negedge clk);
    chk("rst_vid_valid", vid_valid, 0); chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_mem_we", mem_we, 0);       chk("rst_cpu_wait", cpu_wait, 0);
    chk("rst_starved", cpu_starved, 0); chk("rst_mem_addr", mem_addr, 0);
    chk("rst_vid_data", vid_data, 0);   chk("rst_cpu_rdata", cpu_rdata, 0);
    cyc(); rst = 1'b0;

    // Uncontended CPU read
    cpu_req = 1; cpu_we = 0; cpu_addr = 14'h1800;
    cpu_exp.push_back(model[14'h1800]); last_rd = model[14'h1800];
    @(negedge clk); chk("rd_wait0", cpu_wait, 0); cyc();
    @(negedge clk); chk("rd_mem_addr", mem_addr, 14'h1800); chk("rd_mem_we", mem_we, 0); cyc();
    @(negedge clk); chk("rd_ack_c2", cpu_ack, 0); cyc();
    @(negedge clk); chk("rd_ack_c3", cpu_ack, 1); chk("rd_rdata", cpu_rdata, 8'h47); cyc();
    cpu_req = 0;
    @(negedge clk); chk("rd_ack_c4", cpu_ack, 0); cyc(); cyc();

    // Contention: video cycles 0-3, CPU from cycle 0
    for (int i = 0; i < 4; i++) begin
      vid_req = 1; vid_addr = 14'(i); vid_exp.push_back(model[i]);
      if (i == 0) begin
        cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0020;
        cpu_exp.push_back(model[14'h20]); last_rd = model[14'h20];
      end
      @(negedge clk);
      chk("ct_wait", cpu_wait, 1); chk("ct_mem_addr", mem_addr, i);
      chk("ct_vid_valid", vid_valid, (i >= 2));
      cyc();
    end
    vid_req = 0;
    @(negedge clk); chk("ct_wait4", cpu_wait, 0); chk("ct_issue_addr", mem_addr, 14'h20);
    chk("ct_vid_valid4", vid_valid, 1); cyc();
    @(negedge clk); chk("ct_ack5", cpu_ack, 0); chk("ct_vid_valid5", vid_valid, 1); cyc();
    @(negedge clk); chk("ct_ack6", cpu_ack, 1); chk("ct_vid_valid6", vid_valid, 0); cyc();
    cpu_req = 0; cyc(); cyc();

    // Starvation: 8 video cycles with CPU pending
    for (int i = 0; i < 8; i++) begin
      vid_req = 1; vid_addr = 14'(14'h100 + i); vid_exp.push_back(model[14'h100 + i]);
      if (i == 0) begin
        cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0021;
        cpu_exp.push_back(model[14'h21]); last_rd = model[14'h21];
      end
      @(negedge clk); chk("sv_starved", cpu_starved, (i >= 5)); chk("sv_wait", cpu_wait, 1);
      cyc();
    end
    vid_req = 0;
    @(negedge clk); chk("sv_starved_issue", cpu_starved, 1); chk("sv_issue_addr", mem_addr, 14'h21); cyc();
    @(negedge clk); chk("sv_starved_clr", cpu_starved, 0); cyc();
    @(negedge clk); chk("sv_ack", cpu_ack, 1); cyc();
    cpu_req = 0; cyc(); cyc(); cyc();

    // CPU write, then video read of the same address
    cpu_req = 1; cpu_we = 1; cpu_addr = 14'h0010; cpu_wdata = 8'hAA;
    cpu_exp.push_back(last_rd); cyc();
    @(negedge clk); chk("wr_mem_we", mem_we, 1); chk("wr_mem_addr", mem_addr, 14'h10);
    chk("wr_mem_wdata", mem_wdata, 8'hAA); model[14'h10] = 8'hAA; cyc();
    @(negedge clk); chk("wr_mem_we_off", mem_we, 0); cyc();
    @(negedge clk); chk("wr_ack", cpu_ack, 1); chk("wr_rdata_kept", cpu_rdata, last_rd); cyc();
    cpu_req = 0; cpu_we = 0; cyc();
    vid_req = 1; vid_addr = 14'h0010; vid_exp.push_back(model[14'h10]); cyc();
    vid_req = 0; cyc();
    @(negedge clk); chk("wr_vid_valid", vid_valid, 1); chk("wr_vid_data", vid_data, 8'hAA); cyc();

    // Same-cycle collision: video reads old data, CPU write lands after
    vid_req = 1; vid_addr = 14'h0030; vid_exp.push_back(model[14'h30]);
    cpu_req = 1; cpu_we = 1; cpu_addr = 14'h0030; cpu_wdata = 8'h55; cpu_exp.push_back(last_rd);
    @(negedge clk); chk("col_wait", cpu_wait, 1); cyc();
    vid_req = 0;
    @(negedge clk); chk("col_mem_we", mem_we, 1); chk("col_mem_addr", mem_addr, 14'h30); cyc();
    @(negedge clk); chk("col_old_data", vid_data, 8'h30 ^ 8'h3C); model[14'h30] = 8'h55; cyc();
    cyc(); cpu_req = 0; cpu_we = 0; cyc();
    vid_req = 1; vid_addr = 14'h0030; vid_exp.push_back(model[14'h30]); cyc();
    vid_req = 0; cyc();
    @(negedge clk); chk("col_new_data", vid_data, 8'h55); cyc();

    // Reset while a CPU read is in flight
    cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0040; cyc();
    @(negedge clk); chk("rs_issue_addr", mem_addr, 14'h40); cyc();
    rst = 1; cpu_req = 0; vid_req = 1; vid_addr = 14'h0041;
    @(negedge clk); chk("rs_ack_in_rst", cpu_ack, 0); cyc();
    rst = 0; vid_req = 0; last_rd = 8'h00;
    @(negedge clk); chk("rs_ack", cpu_ack, 0); chk("rs_vid_valid", vid_valid, 0);
    chk("rs_mem_we", mem_we, 0); chk("rs_wait", cpu_wait, 0); chk("rs_rdata", cpu_rdata, 0); cyc();
    @(negedge clk); chk("rs_ack_late", cpu_ack, 0); chk("rs_vid_late", vid_valid, 0); cyc(); cyc();

`ifdef VRAM_ARB_STATS_EN
    stat_clr = 1; cyc(); stat_clr = 0;
    @(negedge clk); chk("st_clr0", stat_cont, 0);
    for (int i = 0; i < 5; i++) begin
      vid_req = 1; vid_addr = 14'(14'h200 + i); vid_exp.push_back(model[14'h200 + i]);
      if (i == 0) begin
        cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0022;
        cpu_exp.push_back(model[14'h22]); last_rd = model[14'h22];
      end
      cyc();
    end
    vid_req = 0;
    @(negedge clk); chk("st_cont5", stat_cont, 5); cyc(); cyc(); cyc();
    cpu_req = 0; cyc(); cyc();
    for (int i = 0; i < 4; i++) begin
      vid_req = 1; vid_addr = 14'(14'h210 + i); vid_exp.push_back(model[14'h210 + i]);
      stat_clr = (i == 1);
      if (i == 0) begin
        cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0023;
        cpu_exp.push_back(model[14'h23]); last_rd = model[14'h23];
      end
      @(negedge clk); chk("st_clr_seq", stat_cont, (i == 0) ? 5 : (i == 1) ? 6 : i - 2);
      cyc();
    end
    vid_req = 0; stat_clr = 0;
    @(negedge clk); chk("st_resume", stat_cont, 2); cyc(); cyc(); cyc();
    cpu_req = 0; cyc(); cyc();
`endif

    cyc(); cyc(); cyc();
    chk("vid_queue_drained", vid_exp.size(), 0);
    chk("cpu_queue_drained", cpu_exp.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one synchronous video-RAM port between the video fetcher (pixel/attribute reads) and the CPU (reads/writes).
- Sits between the machine core's ULA timing logic and the block RAM, in the `clk` domain (the 7 MHz machine clock).
- Video always has priority. The CPU is stalled via `cpu_wait` while contended, which reproduces Spectrum-style memory contention.

Parameters:
- AW, 14, VRAM address width (16 KB bank).
- STARVE_MAX, 6, consecutive contended cycles after which `cpu_starved` asserts (diagnostic only; priority never changes).

Ports:
- clk  in  1  machine clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- vid_req  in  1  one-cycle fetch request; must be honoured the same cycle
- vid_addr  in  AW  fetch address, valid with `vid_req`
- vid_data  out  8  fetched byte
- vid_valid  out  1  one-cycle pulse, `vid_data` valid
- cpu_req  in  1  level request, held until `cpu_ack`
- cpu_we  in  1  1 = write, 0 = read; stable while `cpu_req`
- cpu_addr  in  AW  CPU address, stable while `cpu_req`
- cpu_wdata  in  8  write data
- cpu_rdata  out  8  read data, valid with `cpu_ack`
- cpu_ack  out  1  one-cycle completion pulse
- cpu_wait  out  1  high while a CPU request is pending but not yet issued
- cpu_starved  out  1  high while the contended-cycle count ≥ STARVE_MAX
- mem_addr  out  AW  RAM address
- mem_wdata  out  8  RAM write data
- mem_we  out  1  RAM write enable
- mem_rdata  in  8  RAM read data, 1-cycle latency after address

Behaviour:
- Reset values: all outputs 0; CPU FSM returns to C_IDLE; the in-flight pipeline is cleared.
- Reset mid-access: the access is discarded; no `vid_valid` or `cpu_ack` is generated for it.
- Each cycle, the issue stage selects one of:
  - video, if `vid_req` is high;
  - otherwise CPU, if its FSM is in C_PEND;
  - otherwise idle (`mem_we` = 0, `mem_addr` holds its last value).
- The issue stage drives `mem_*` combinationally from the winner.
- Pipeline: issue in cycle N; `mem_rdata` is valid in N+1 and is registered into `vid_data`/`cpu_rdata` at the end of N+1. Therefore:
  - `vid_valid` and `cpu_ack` rise in cycle N+2;
  - `vid_data` and `cpu_rdata` hold their value until the next load.
- CPU write: `mem_we` = 1 in its issue cycle only. `cpu_ack` still follows at N+2; `cpu_rdata` is unchanged on writes.
- CPU FSM:
  - C_IDLE → C_PEND when `cpu_req` = 1.
  - C_PEND → C_FLIGHT on the cycle the CPU wins the port.
  - C_FLIGHT → C_ACK after 1 cycle.
  - C_ACK emits `cpu_ack`, then → C_HOLD.
  - C_HOLD → C_IDLE when `cpu_req` = 0. The requester must drop `cpu_req` after `cpu_ack`; while it stays high, no second access is started.
- `cpu_wait` = (state == C_PEND) && `vid_req`. It is also high in the cycle `cpu_req` first rises if `vid_req` is high in that cycle.
- Uncontended CPU access: `cpu_req` rises in cycle 0 → issued cycle 1 → `cpu_ack` cycle 3.
- Contention counter:
  - 4-bit, increments each cycle `cpu_wait` = 1, saturating at 15;
  - clears when the CPU issues or on `rst`;
  - `cpu_starved` = count ≥ STARVE_MAX.
- Same-address collision: the video read issued first returns the old data; the deferred CPU write lands afterwards. No forwarding.
- Video may request every cycle; `vid_valid` then pulses every cycle with a 2-cycle lag. A CPU waiting under back-to-back video is starved indefinitely, by design.

Optional Feature:
- Macro: VRAM_ARB_STATS_EN.
- When defined, the block adds:
  - input `stat_clr` (1 bit);
  - output `stat_cont` (16 bits): a saturating count of all cycles with `cpu_wait` = 1 since reset or since the last `stat_clr` pulse.
- `stat_clr` wins over a simultaneous increment; the counter reads 0 in the following cycle.
- When the macro is undefined, these ports and registers do not exist and all other behaviour is identical.

Test Plan:
- Reset: assert `rst` mid-CPU-read → `cpu_ack`, `vid_valid`, `mem_we`, `cpu_wait` all 0 the next cycle; no late ack.
- Idle CPU read: `cpu_req` = 1, `cpu_we` = 0, `cpu_addr` = 0x1800, RAM holds 0x47 → `mem_addr` = 0x1800 at cycle 1; `cpu_ack` = 1 and `cpu_rdata` = 0x47 at cycle 3.
- Contention:
  - stimulus: `vid_req` high cycles 0–3 (addresses 0x0000–0x0003) while `cpu_req` is high from cycle 0;
  - response: `cpu_wait` = 1 in cycles 0–3; CPU issues at cycle 4, `cpu_ack` at cycle 6; `vid_valid` pulses at cycles 2–5.
- Starvation: `vid_req` held 8 cycles with `cpu_req` pending → `cpu_starved` rises on the 6th contended cycle, then clears the cycle after the CPU issues.
- Write then read: CPU writes 0xAA to 0x0010, drops `cpu_req`, then a video read of 0x0010 → `vid_data` = 0xAA. A collision in the same cycle returns the old value.
- VRAM_ARB_STATS_EN:
  - 5 contended cycles → `stat_cont` = 5;
  - pulse `stat_clr` during a contended cycle → `stat_cont` = 0 next cycle, then resumes counting.
